// File: rtl/ifu_fetch_queue_if.sv
// Port bundle for ifu_fetch_queue: redirect, MMU, memory and IF/ID queue-output channels.
// master = fetch-queue side, slave = surrounding core / test environment.
interface ifu_fetch_queue_if #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              redirect_valid_i;
  logic [ADDR_W-1:0] redirect_pc_i;
  logic              mmu_enable_i;
  logic              mmu_req_valid_o;
  logic [ADDR_W-1:0] mmu_req_vaddr_o;
  logic              mmu_resp_valid_i;
  logic [ADDR_W-1:0] mmu_resp_paddr_i;
  logic              mmu_page_fault_i;
  logic              mem_req_valid_o;
  logic [ADDR_W-1:0] mem_req_addr_o;
  logic              mem_req_ready_i;
  logic              mem_rvalid_i;
  logic [31:0]       mem_rdata_i;
  logic              mem_access_fault_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [ADDR_W-1:0] out_pc_o;
  logic [31:0]       out_inst_o;
  logic              out_page_fault_o;
  logic              out_access_fault_o;
  logic              ram_stall_valid_if_o;
  logic [CNT_W-1:0]  count_o;

  modport master (
    input  redirect_valid_i, redirect_pc_i, mmu_enable_i,
    input  mmu_resp_valid_i, mmu_resp_paddr_i, mmu_page_fault_i,
    input  mem_req_ready_i, mem_rvalid_i, mem_rdata_i, mem_access_fault_i,
    input  out_ready_i,
    output mmu_req_valid_o, mmu_req_vaddr_o,
    output mem_req_valid_o, mem_req_addr_o,
    output out_valid_o, out_pc_o, out_inst_o, out_page_fault_o, out_access_fault_o,
    output ram_stall_valid_if_o, count_o
  );

  modport slave (
    output redirect_valid_i, redirect_pc_i, mmu_enable_i,
    output mmu_resp_valid_i, mmu_resp_paddr_i, mmu_page_fault_i,
    output mem_req_ready_i, mem_rvalid_i, mem_rdata_i, mem_access_fault_i,
    output out_ready_i,
    input  mmu_req_valid_o, mmu_req_vaddr_o,
    input  mem_req_valid_o, mem_req_addr_o,
    input  out_valid_o, out_pc_o, out_inst_o, out_page_fault_o, out_access_fault_o,
    input  ram_stall_valid_if_o, count_o
  );
endinterface

// File: rtl/ifu_fetch_queue.sv
// Instruction-fetch front end: fetch PC sequencer with optional MMU translation,
// single-outstanding memory read and a DEPTH-entry {pc, inst, fault} output queue.
module ifu_fetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h3000_0000
) (
  input logic                clk,
  input logic                rst_n,
  ifu_fetch_queue_if.master  io_bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_XLATE, S_ISSUE, S_WAIT, S_DROP, S_HALT
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;
  logic [ADDR_W-1:0] r_paddr, w_paddr_nxt;
  logic [PTR_W-1:0]  r_rd_ptr, r_wr_ptr;
  logic [CNT_W-1:0]  r_count;

  logic [ADDR_W-1:0] r_q_pc   [DEPTH];
  logic [31:0]       r_q_inst [DEPTH];
  logic              r_q_pf   [DEPTH];
  logic              r_q_af   [DEPTH];

  logic              w_redirect;
  logic [ADDR_W-1:0] w_redirect_pc;
  logic              w_out_valid, w_pop;
  logic              w_push, w_push_pf, w_push_af;
  logic [31:0]       w_push_inst;
  logic              w_mmu_req_valid, w_mem_req_valid;

  assign w_redirect    = io_bus.redirect_valid_i;
  assign w_redirect_pc = {io_bus.redirect_pc_i[ADDR_W-1:2], 2'b00};
  assign w_out_valid   = (r_count != '0);
  assign w_pop         = w_out_valid && io_bus.out_ready_i;

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_paddr_nxt     = r_paddr;
    w_push          = 1'b0;
    w_push_inst     = '0;
    w_push_pf       = 1'b0;
    w_push_af       = 1'b0;
    w_mmu_req_valid = 1'b0;
    w_mem_req_valid = 1'b0;

    case (r_state)
      S_IDLE: begin
        // Only IDLE launches, so nothing is in flight here; a free slot is the reservation.
        if (r_count < FULL) begin
          if (io_bus.mmu_enable_i) begin
            w_state_nxt = S_XLATE;
          end else begin
            w_paddr_nxt = r_pc;
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_XLATE: begin
        w_mmu_req_valid = 1'b1;
        if (io_bus.mmu_resp_valid_i) begin
          if (io_bus.mmu_page_fault_i) begin
            w_push      = 1'b1;
            w_push_pf   = 1'b1;
            w_state_nxt = S_HALT;
          end else begin
            w_paddr_nxt = io_bus.mmu_resp_paddr_i;
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        w_mem_req_valid = 1'b1;
        if (io_bus.mem_req_ready_i) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (io_bus.mem_rvalid_i) begin
          w_push      = 1'b1;
          w_push_af   = io_bus.mem_access_fault_i;
          w_push_inst = io_bus.mem_access_fault_i ? '0 : io_bus.mem_rdata_i;
          w_pc_nxt    = r_pc + ADDR_W'(4);
          w_state_nxt = io_bus.mem_access_fault_i ? S_HALT : S_IDLE;
        end
      end
      S_DROP: begin
        if (io_bus.mem_rvalid_i) w_state_nxt = S_IDLE;
      end
      S_HALT: ;
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_redirect) begin
      w_pc_nxt = w_redirect_pc;
      w_push   = 1'b0;
      // A response landing in the redirect cycle is already consumed, so there is nothing left to drop.
      case (r_state)
        S_WAIT, S_DROP: w_state_nxt = io_bus.mem_rvalid_i ? S_IDLE : S_DROP;
        S_ISSUE:        w_state_nxt = io_bus.mem_req_ready_i ? S_DROP : S_IDLE;
        default:        w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_paddr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_paddr <= w_paddr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (w_redirect) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_wr_ptr]   <= r_pc;
      r_q_inst[r_wr_ptr] <= w_push_inst;
      r_q_pf[r_wr_ptr]   <= w_push_pf;
      r_q_af[r_wr_ptr]   <= w_push_af;
    end
  end

  assign io_bus.mmu_req_valid_o      = w_mmu_req_valid;
  assign io_bus.mmu_req_vaddr_o      = r_pc;
  assign io_bus.mem_req_valid_o      = w_mem_req_valid;
  assign io_bus.mem_req_addr_o       = r_paddr;
  assign io_bus.out_valid_o          = w_out_valid;
  assign io_bus.out_pc_o             = w_out_valid ? r_q_pc[r_rd_ptr]   : '0;
  assign io_bus.out_inst_o           = w_out_valid ? r_q_inst[r_rd_ptr] : '0;
  assign io_bus.out_page_fault_o     = w_out_valid && r_q_pf[r_rd_ptr];
  assign io_bus.out_access_fault_o   = w_out_valid && r_q_af[r_rd_ptr];
  assign io_bus.ram_stall_valid_if_o = !w_out_valid;
  assign io_bus.count_o              = r_count;
endmodule

// File: doc/ifu_fetch_queue.md
# ifu_fetch_queue

Parametrised instruction-fetch front end that replaces the single-entry, stall-driven fetch path. Owns the fetch PC and sequences each fetch through optional MMU translation and a single-outstanding memory read. Fetched {pc, inst, fault} entries go into a DEPTH-entry queue that feeds the IF/ID register with a valid/ready handshake. Handles redirect and flush with drop-on-return of in-flight data, and reports instruction page and access faults per entry.

## Interface
- ADDR_W, 32, virtual and physical address width.
- DEPTH, 4, queue entries; power of two, ≥2.
- RESET_PC, 32'h3000_0000, fetch PC after reset.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- redirect_valid_i  in  1  flush queue and restart fetch at redirect_pc_i.
- redirect_pc_i  in  ADDR_W  new fetch PC; bits[1:0] ignored, treated as 0.
- mmu_enable_i  in  1  1 = translate through the MMU; 0 = physical address equals virtual address.
- mmu_req_valid_o  out  1  translation request.
- mmu_req_vaddr_o  out  ADDR_W  virtual PC to translate.
- mmu_resp_valid_i  in  1  translation done.
- mmu_resp_paddr_i  in  ADDR_W  translated address.
- mmu_page_fault_i  in  1  page fault; qualified by mmu_resp_valid_i.
- mem_req_valid_o  out  1  read request.
- mem_req_addr_o  out  ADDR_W  physical read address.
- mem_req_ready_i  in  1  request accepted.
- mem_rvalid_i  in  1  read data returned.
- mem_rdata_i  in  32  instruction word.
- mem_access_fault_i  in  1  bus error; qualified by mem_rvalid_i.
- out_valid_o  out  1  queue head valid.
- out_ready_i  in  1  consumer takes the head.
- out_pc_o  out  ADDR_W  head PC.
- out_inst_o  out  32  head instruction; 0 on a faulted entry.
- out_page_fault_o  out  1  head carries an instruction page fault.
- out_access_fault_o  out  1  head carries an instruction access fault.
- ram_stall_valid_if_o  out  1  equals !out_valid_o.
- count_o  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- Fetch state machine states: IDLE, XLATE, ISSUE, WAIT, DROP, HALT.
- IDLE: start a fetch when count_o + (in-flight) < DEPTH, so every request has a reserved slot.
  - mmu_enable_i=1: go to XLATE.
  - mmu_enable_i=0: latch paddr = pc, go to ISSUE.
- XLATE: hold mmu_req_valid_o=1 and mmu_req_vaddr_o=pc until mmu_resp_valid_i.
  - No fault: latch paddr, go to ISSUE.
  - Page fault: enqueue {pc, 0, pf=1}, go to HALT.
- ISSUE: hold mem_req_valid_o=1 and mem_req_addr_o=paddr until mem_req_ready_i, then go to WAIT.
- WAIT: on mem_rvalid_i, enqueue {pc, rdata, af=mem_access_fault_i}, pc += 4 (wraps modulo 2^ADDR_W).
  - Access fault: go to HALT (inst forced 0).
  - Otherwise: go to IDLE.
- HALT: no requests until redirect_valid_i.
- Redirect (any state): queue emptied, pc ← {redirect_pc_i[ADDR_W-1:2], 2'b00}.
  - From WAIT: go to DROP.
  - From ISSUE: the request is withdrawn only if not yet accepted; if mem_req_ready_i is high in the same cycle, go to DROP.
  - From any other state: go to IDLE.
- DROP: discard the next mem_rvalid_i, then go to IDLE. A redirect arriving in DROP updates pc and stays in DROP.
- XLATE aborted by a redirect: the MMU response is ignored; the MMU must tolerate request withdrawal.
- Queue: circular buffer with read/write pointers plus count.
  - Pop when out_valid_o && out_ready_i.
  - Push and pop in the same cycle: count unchanged.
  - Full: no push can occur because of slot reservation.
  - Redirect in the same cycle as push or pop: the redirect wins; queue empty next cycle.

## Timing
- Reset values:
  - State: IDLE; pc = RESET_PC; count_o = 0; pointers = 0.
  - All valid outputs 0; out_* data 0; ram_stall_valid_if_o = 1.
  - Reset mid-transaction drops all in-flight state; any later mem_rvalid_i is ignored until a new request is accepted.
- Request launch: earliest mem_req_valid_o is the cycle after IDLE with translation off, or the cycle after mmu_resp_valid_i with translation on.
- Enqueue: data is enqueued on the mem_rvalid_i edge; out_valid_o rises the following cycle (registered queue, no bypass).
- Best case, translation off, ready and rvalid each in the first possible cycle:
  - IDLE → ISSUE → WAIT → rvalid, out_valid_o high 3 cycles after leaving reset.
  - Steady throughput: one word per 3 cycles.
- Redirect to the first new mem_req_valid_o: 2 cycles (redirect edge → IDLE → ISSUE).

## Test plan
- Translation off, ready/rvalid immediate, out_ready_i=1:
  - Expect PCs 0x3000_0000, 0x3000_0004, 0x3000_0008 in order, with matching rdata.
- out_ready_i=0, DEPTH=4:
  - Exactly 4 entries enqueue, count_o=4, mem_req_valid_o stays 0.
  - Raise out_ready_i for one cycle: exactly one new fetch starts.
- Redirect to 0x8000_0010 while in WAIT:
  - The returning rdata is dropped, the queue is empty.
  - The next request address is 0x8000_0010.
- Translation on, MMU returns paddr 0x0010_2000 for vaddr 0x8000_2000:
  - mem_req_addr_o=0x0010_2000, out_pc_o=0x8000_2000.
- MMU page fault at 0x8000_3000:
  - Entry {0x8000_3000, inst 0, pf=1} is output, then no requests.
  - Redirect resumes fetch.
- Assert rst_n=0 while in ISSUE:
  - All outputs return to reset values immediately; fetch restarts at RESET_PC after release.
